// File: rtl/pacman_input_conditioner.sv
// -----------------------------------------------------------------------------
// pacman_input_conditioner
//
// Purpose:
//   Conditions the five raw push-buttons of the Pac-Man front panel into clean
//   commands for the movement stage. Each button is synchronized (2 flops),
//   debounced against a cycle count, and edge-detected into a one-cycle press
//   flag. Direction presses load a sticky direction register; the centre
//   button produces either a start pulse (game running) or a game-over
//   acknowledge pulse (win/lose asserted).
//
// Ports:
//   clk                     system clock, all state on rising edge
//   reset                   asynchronous active-low reset
//   BtnL/BtnR/BtnU/BtnD/BtnC raw asynchronous buttons, active-high
//   win, lose               game-over levels from the movement stage
//   Left/Right/Up/Down      held direction command, at most one high
//   start                   one-cycle start pulse
//   ack                     one-cycle game-over acknowledge pulse
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module pacman_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic BtnL,
  input  logic BtnR,
  input  logic BtnU,
  input  logic BtnD,
  input  logic BtnC,
  input  logic win,
  input  logic lose,
  output logic Left,
  output logic Right,
  output logic Up,
  output logic Down,
  output logic start,
  output logic ack
);

  localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Button index map: 0=L 1=R 2=U 3=D 4=C
  localparam int LP_NBTN = 5;
  localparam int LP_C    = 4;

  typedef enum logic [2:0] {
    DIR_NONE = 3'd0,
    DIR_L    = 3'd1,
    DIR_R    = 3'd2,
    DIR_U    = 3'd3,
    DIR_D    = 3'd4
  } dir_t;

  logic [LP_NBTN-1:0] w_btn;
  logic [LP_NBTN-1:0] r_s1;
  logic [LP_NBTN-1:0] r_s2;
  logic [LP_NBTN-1:0] r_stable;
  logic [LP_NBTN-1:0] r_press;
  logic [CNT_W-1:0]   r_cnt [LP_NBTN];

  dir_t r_dir;
  dir_t w_dir_next;
  logic w_start_next;
  logic w_ack_next;

  assign w_btn = {BtnC, BtnD, BtnU, BtnR, BtnL};

  // Synchronizer, debounce counter and press-flag generation per button.
  // The press flag is registered at the same edge that stable rises, so it is
  // high for exactly the cycle following that edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_stable <= '0;
      r_press  <= '0;
      for (int i = 0; i < LP_NBTN; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_s1 <= w_btn;
      r_s2 <= r_s1;
      for (int i = 0; i < LP_NBTN; i++) begin
        r_press[i] <= 1'b0;
        if (r_s2[i] == r_stable[i]) begin
          // Any disagreement shorter than the threshold is forgotten here.
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == LP_CNT_MAX) begin
          r_stable[i] <= r_s2[i];
          r_cnt[i]    <= '0;
          r_press[i]  <= r_s2[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Direction / start / ack next-state. Priority, lowest first: single
  // direction press, centre-button start clear, game-over force to NONE.
  always_comb begin
    w_dir_next   = r_dir;
    w_start_next = 1'b0;
    w_ack_next   = 1'b0;

    case (r_press[3:0])
      4'b0001: w_dir_next = DIR_L;
      4'b0010: w_dir_next = DIR_R;
      4'b0100: w_dir_next = DIR_U;
      4'b1000: w_dir_next = DIR_D;
      default: w_dir_next = r_dir;  // none or simultaneous presses: hold
    endcase

    if (r_press[LP_C]) begin
      if (win || lose) begin
        w_ack_next = 1'b1;
      end else begin
        w_start_next = 1'b1;
        w_dir_next   = DIR_NONE;
      end
    end

    if (win || lose) begin
      w_dir_next = DIR_NONE;
    end
  end

  // Outputs are registered from the next-state decode so they are pure flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dir <= DIR_NONE;
      Left  <= 1'b0;
      Right <= 1'b0;
      Up    <= 1'b0;
      Down  <= 1'b0;
      start <= 1'b0;
      ack   <= 1'b0;
    end else begin
      r_dir <= w_dir_next;
      Left  <= (w_dir_next == DIR_L);
      Right <= (w_dir_next == DIR_R);
      Up    <= (w_dir_next == DIR_U);
      Down  <= (w_dir_next == DIR_D);
      start <= w_start_next;
      ack   <= w_ack_next;
    end
  end

endmodule

// File: tb/tb_pacman_input_conditioner.sv
module tb_pacman_input_conditioner;

  localparam int DC = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic reset;
  logic btn_l, btn_r, btn_u, btn_d, btn_c;
  logic win, lose;
  logic left_o, right_o, up_o, down_o, start_o, ack_o;

  int n_checks = 0;
  int n_fail   = 0;

  pacman_input_conditioner #(.DEBOUNCE_CYCLES(DC), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .BtnL  (btn_l),
    .BtnR  (btn_r),
    .BtnU  (btn_u),
    .BtnD  (btn_d),
    .BtnC  (btn_c),
    .win   (win),
    .lose  (lose),
    .Left  (left_o),
    .Right (right_o),
    .Up    (up_o),
    .Down  (down_o),
    .start (start_o),
    .ack   (ack_o)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit after it.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [5:0] outs();
    return {left_o, right_o, up_o, down_o, start_o, ack_o};
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    btn_l = 0; btn_r = 0; btn_u = 0; btn_d = 0; btn_c = 0;
    win = 0; lose = 0;
    tick(3);
    n_checks++;
    if (outs() !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs actual=%b required=000000", outs());
    end
    n_checks++;
    if (dut.r_stable !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_stable actual=%b required=00000", dut.r_stable);
    end
    reset = 1'b1;
    tick(2);
    n_checks++;
    if (outs() !== 6'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle actual=%b required=000000", outs());
    end
  endtask

  // BtnL held from edge 0: stable after edge 6, Left after edge 7, sticky.
  task automatic test_debounce_left();
    btn_l = 1'b1;
    tick(5);
    n_checks++;
    if (dut.r_stable[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL stableL_edge5 actual=%b required=0", dut.r_stable[0]);
    end
    tick(1);
    n_checks++;
    if (dut.r_stable[0] !== 1'b1 || left_o !== 1'b0) begin
      n_fail++;
      $display("FAIL stableL_edge6 actual=stable%b/left%b required=stable1/left0",
               dut.r_stable[0], left_o);
    end
    tick(1);
    n_checks++;
    if (outs() !== 6'b100000) begin
      n_fail++;
      $display("FAIL left_edge7 actual=%b required=100000", outs());
    end
    btn_l = 1'b0;
    tick(12);
    n_checks++;
    if (outs() !== 6'b100000) begin
      n_fail++;
      $display("FAIL left_sticky actual=%b required=100000", outs());
    end
  endtask

  // BtnU high for 3 cycles (one short of threshold): never accepted.
  task automatic test_glitch();
    btn_u = 1'b1;
    for (int t = 1; t <= 15; t++) begin
      tick(1);
      if (t == 3) btn_u = 1'b0;
      n_checks++;
      if (outs() !== 6'b100000) begin
        n_fail++;
        $display("FAIL glitch_t%0d actual=%b required=100000", t, outs());
      end
    end
    n_checks++;
    if (dut.r_cnt[2] !== 3'd0 || dut.r_stable[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_cnt actual=cnt%0d/stable%b required=cnt0/stable0",
               dut.r_cnt[2], dut.r_stable[2]);
    end
  endtask

  // Establish Down, then L+R pressed together must leave Down in place.
  task automatic test_double_press();
    btn_d = 1'b1;
    tick(7);
    n_checks++;
    if (outs() !== 6'b000100) begin
      n_fail++;
      $display("FAIL down_load actual=%b required=000100", outs());
    end
    btn_d = 1'b0;
    tick(8);
    btn_l = 1'b1;
    btn_r = 1'b1;
    tick(10);
    n_checks++;
    if (outs() !== 6'b000100) begin
      n_fail++;
      $display("FAIL double_press actual=%b required=000100", outs());
    end
    btn_l = 1'b0;
    btn_r = 1'b0;
    tick(8);
  endtask

  // BtnC held 50 cycles while playing: single start pulse after edge 7.
  task automatic test_start();
    btn_c = 1'b1;
    for (int t = 1; t <= 50; t++) begin
      tick(1);
      n_checks++;
      if (start_o !== (t == 7) || ack_o !== 1'b0) begin
        n_fail++;
        $display("FAIL start_t%0d actual=start%b/ack%b required=start%b/ack0",
                 t, start_o, ack_o, (t == 7));
      end
      if (t == 6 || t == 7 || t == 30) begin
        n_checks++;
        if ({left_o, right_o, up_o, down_o} !== ((t < 7) ? 4'b0001 : 4'b0000)) begin
          n_fail++;
          $display("FAIL start_dir_t%0d actual=%b required=%b", t,
                   {left_o, right_o, up_o, down_o}, (t < 7) ? 4'b0001 : 4'b0000);
        end
      end
    end
    btn_c = 1'b0;
    tick(8);
  endtask

  // lose=1 with BtnC and BtnR pressed: ack pulse, no start, no direction.
  task automatic test_lose_ack();
    lose  = 1'b1;
    btn_c = 1'b1;
    btn_r = 1'b1;
    for (int t = 1; t <= 15; t++) begin
      tick(1);
      n_checks++;
      if (outs() !== ((t == 7) ? 6'b000001 : 6'b000000)) begin
        n_fail++;
        $display("FAIL lose_ack_t%0d actual=%b required=%b", t, outs(),
                 (t == 7) ? 6'b000001 : 6'b000000);
      end
    end
    btn_c = 1'b0;
    btn_r = 1'b0;
    tick(8);
    lose = 1'b0;
    tick(1);
  endtask

  // Start press and direction press in the same cycle: start clear wins.
  task automatic test_start_and_dir();
    btn_d = 1'b1;
    tick(7);
    btn_d = 1'b0;
    tick(8);
    n_checks++;
    if (outs() !== 6'b000100) begin
      n_fail++;
      $display("FAIL pre_combo_down actual=%b required=000100", outs());
    end
    btn_c = 1'b1;
    btn_l = 1'b1;
    tick(6);
    n_checks++;
    if (outs() !== 6'b000100) begin
      n_fail++;
      $display("FAIL combo_edge6 actual=%b required=000100", outs());
    end
    tick(1);
    n_checks++;
    if (outs() !== 6'b000010) begin
      n_fail++;
      $display("FAIL combo_edge7 actual=%b required=000010", outs());
    end
    tick(1);
    n_checks++;
    if (outs() !== 6'b000000) begin
      n_fail++;
      $display("FAIL combo_edge8 actual=%b required=000000", outs());
    end
    btn_c = 1'b0;
    btn_l = 1'b0;
    tick(8);
  endtask

  // Reset mid-debounce discards the count; held BtnR restarts from scratch.
  task automatic test_reset_mid();
    btn_u = 1'b1;
    tick(7);
    btn_u = 1'b0;
    tick(8);
    n_checks++;
    if (outs() !== 6'b001000) begin
      n_fail++;
      $display("FAIL pre_reset_up actual=%b required=001000", outs());
    end
    btn_r = 1'b1;
    tick(4);
    reset = 1'b0;
    #1;
    n_checks++;
    if (outs() !== 6'b0 || dut.r_cnt[1] !== 3'd0 || dut.r_s2 !== 5'b0) begin
      n_fail++;
      $display("FAIL async_reset actual=%b/cnt%0d/s2%b required=000000/cnt0/s200000",
               outs(), dut.r_cnt[1], dut.r_s2);
    end
    tick(2);
    reset = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      tick(1);
      n_checks++;
      if (right_o !== (t == 7)) begin
        n_fail++;
        $display("FAIL reset_rel_t%0d actual=%b required=%b", t, right_o, (t == 7));
      end
    end
    btn_r = 1'b0;
  endtask

  initial begin
    test_reset();
    test_debounce_left();
    test_glitch();
    test_double_press();
    test_start();
    test_lose_ack();
    test_start_and_dir();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
